// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: exception codes, memory access size
// encoding, the execute-stage request-tracking state type and alignment helpers.
package cpu_pkg;

    localparam logic [5:0] ECODE_ALE  = 6'h09;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;
    localparam logic [1:0] MEM_SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } ex_state_t;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            MEM_SIZE_B: mask = 3'b000;
            MEM_SIZE_H: mask = 3'b001;
            MEM_SIZE_W: mask = 3'b011;
            MEM_SIZE_D: mask = 3'b111;
            default:    mask = 3'b000;
        endcase
        return mask;
    endfunction

    // True when a memory access is not naturally aligned to its size.
    function automatic logic misaligned(input logic is_mem, input logic [1:0] size,
                                        input logic [2:0] addr_lo);
        return is_mem & ((addr_lo & size_mask(size)) != 3'b000);
    endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Generic 1-entry valid/ready skid buffer with flush. The upstream ready is a
// pure register (skid empty), so no combinational path runs from m_ready back
// to s_ready. Order is preserved; flush empties both slots.
module ex_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         m_valid_r;
    logic [W-1:0] m_data_r;
    logic         skid_valid_r;
    logic [W-1:0] skid_data_r;
    logic         out_free_s;
    logic         accept_s;

    assign out_free_s = ~m_valid_r | m_ready;
    assign accept_s   = s_valid & ~skid_valid_r;
    assign s_ready    = ~skid_valid_r;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;

    // Output slot and skid slot: refill output from skid first, else from input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_r    <= 1'b0;
            m_data_r     <= {W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {W{1'b0}};
        end else if (flush) begin
            m_valid_r    <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                m_valid_r    <= 1'b1;
                m_data_r     <= skid_data_r;
                skid_valid_r <= 1'b0;
            end else begin
                m_valid_r <= s_valid;
                if (s_valid) begin
                    m_data_r <= s_data;
                end
            end
        end else if (accept_s) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= s_data;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute-stage pipeline register. Issues each multi-cycle unit request exactly
// once per instruction, holds the result while downstream stalls, cancels an
// accepted request on kill, flags misaligned accesses, and counts stall cycles.
module ex_stage_pipe #(
    parameter int PAYLOAD_W = 128,
    parameter int ADDR_W    = 32,
    parameter int NUM_FU    = 2,
    parameter int SKID      = 0,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [NUM_FU-1:0]    in_fu_sel,
    input  logic                 in_is_mem,
    input  logic [1:0]           in_mem_size,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic                 in_exc,
    input  logic [5:0]           in_ecode,
    input  logic [ADDR_W-1:0]    in_badv,
    input  logic                 kill,
    output logic [NUM_FU-1:0]    fu_req_valid,
    input  logic [NUM_FU-1:0]    fu_req_ready,
    output logic [NUM_FU-1:0]    fu_cancel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_exc,
    output logic [5:0]           out_ecode,
    output logic [ADDR_W-1:0]    out_badv,
    output logic [CNT_W-1:0]     stall_cnt
);

    import cpu_pkg::*;

    localparam int DW = PAYLOAD_W + 1 + 6 + ADDR_W;

    ex_state_t             state_r;
    ex_state_t             state_nxt_s;
    logic [NUM_FU-1:0]     sel_r;
    logic [NUM_FU-1:0]     fu_cancel_r;
    logic [NUM_FU-1:0]     cancel_nxt_s;
    logic [NUM_FU-1:0]     req_s;
    logic [NUM_FU-1:0]     fire_vec_s;
    logic [CNT_W-1:0]      stall_cnt_r;
    logic                  ale_s;
    logic                  suppress_s;
    logic                  is_fu_s;
    logic                  fire_s;
    logic                  ready_go_s;
    logic                  int_ready_s;
    logic                  push_s;
    logic                  exc_s;
    logic [5:0]            ecode_s;
    logic [ADDR_W-1:0]     badv_s;
    logic [DW-1:0]         bundle_s;
    logic [DW-1:0]         out_bundle_s;

    assign ale_s      = misaligned(in_is_mem, in_mem_size, in_addr[2:0]);
    assign suppress_s = in_exc | ale_s | kill;
    assign is_fu_s    = |in_fu_sel;
    // resetn gating keeps requests quiet while the stage is held in reset.
    assign req_s      = in_fu_sel & {NUM_FU{in_valid & ~suppress_s & (state_r != S_HOLD) & resetn}};
    assign fire_vec_s = req_s & fu_req_ready;
    assign fire_s     = |fire_vec_s;
    assign ready_go_s = ~in_valid | suppress_s | ~is_fu_s | fire_s | (state_r == S_HOLD);
    assign push_s     = in_valid & ready_go_s;
    assign in_ready   = ~in_valid | (ready_go_s & int_ready_s);

    assign exc_s    = in_exc | ale_s;
    assign ecode_s  = in_exc ? in_ecode : (ale_s ? ECODE_ALE : 6'h00);
    assign badv_s   = in_exc ? in_badv : (ale_s ? in_addr : {ADDR_W{1'b0}});
    assign bundle_s = {in_payload, exc_s, ecode_s, badv_s};

    assign fu_req_valid = req_s;
    assign fu_cancel    = fu_cancel_r;
    assign stall_cnt    = stall_cnt_r;
    assign {out_payload, out_exc, out_ecode, out_badv} = out_bundle_s;

    // Next-state and cancel selection for the request-tracking FSM.
    always_comb begin
        state_nxt_s  = state_r;
        cancel_nxt_s = {NUM_FU{1'b0}};
        if (kill) begin
            state_nxt_s = S_IDLE;
            if (state_r == S_HOLD) begin
                cancel_nxt_s = sel_r;
            end else begin
                cancel_nxt_s = fire_vec_s;
            end
        end else begin
            case (state_r)
                S_IDLE, S_REQ: begin
                    if (fire_s) begin
                        state_nxt_s = int_ready_s ? S_IDLE : S_HOLD;
                    end else if (in_valid & is_fu_s & ~suppress_s) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (int_ready_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_HOLD;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // FSM state, the unit that accepted the last request, and the cancel pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_IDLE;
            sel_r       <= {NUM_FU{1'b0}};
            fu_cancel_r <= {NUM_FU{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            fu_cancel_r <= cancel_nxt_s;
            if (fire_s) begin
                sel_r <= fire_vec_s;
            end
        end
    end

    // Saturating count of cycles in which upstream is held off.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (in_valid & ~in_ready & ~kill & ~(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    if (SKID != 0) begin : g_skid
        logic skid_ready_s;
        ex_skid_buf #(.W(DW)) u_skid (
            .clk     (clk),
            .resetn  (resetn),
            .flush   (kill),
            .s_valid (push_s),
            .s_ready (skid_ready_s),
            .s_data  (bundle_s),
            .m_valid (out_valid),
            .m_ready (out_ready),
            .m_data  (out_bundle_s)
        );
        assign int_ready_s = skid_ready_s;
    end else begin : g_direct
        logic          out_valid_r;
        logic [DW-1:0] out_bundle_r;

        // Direct output register: advances only when downstream accepts.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                out_valid_r  <= 1'b0;
                out_bundle_r <= {DW{1'b0}};
            end else if (kill) begin
                out_valid_r <= 1'b0;
            end else if (out_ready) begin
                out_valid_r <= push_s;
                if (push_s) begin
                    out_bundle_r <= bundle_s;
                end
            end
        end

        assign int_ready_s  = out_ready;
        assign out_valid    = out_valid_r;
        assign out_bundle_s = out_bundle_r;
    end

endmodule
